// File: rtl/pe_ctrl_gen_if.sv
// ============================================================================
// Module      : pe_ctrl_gen_if
// Description : Command handshake, operand-valid and packed PE ctrl bus
//               between the layer scheduler, pe_ctrl_gen and the PE array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pe_ctrl_gen_if #(
   parameter int PE_BUF_ADDR_WIDTH = 10,
   parameter int OP_CODE_WIDTH     = 3,
   parameter int CNT_WIDTH         = 16
);
   localparam int CTRL_WIDTH = 5 + OP_CODE_WIDTH + 2*PE_BUF_ADDR_WIDTH;

   logic                         cfg_valid;
   logic                         cfg_ready;
   logic [OP_CODE_WIDTH-1:0]     cfg_op_code;
   logic [CNT_WIDTH-1:0]         cfg_num_acc;
   logic [CNT_WIDTH-1:0]         cfg_num_out;
   logic                         cfg_acc_from_buf;
   logic [PE_BUF_ADDR_WIDTH-1:0] cfg_rd_base;
   logic [PE_BUF_ADDR_WIDTH-1:0] cfg_wr_base;
   logic                         in_valid;
   logic [CTRL_WIDTH-1:0]        ctrl;
   logic                         busy;
   logic                         done;

   // master: the sequencer (drives ctrl); slave: scheduler / PE-array side
   modport master (
      input  cfg_valid, cfg_op_code, cfg_num_acc, cfg_num_out,
             cfg_acc_from_buf, cfg_rd_base, cfg_wr_base, in_valid,
      output cfg_ready, ctrl, busy, done
   );

   modport slave (
      output cfg_valid, cfg_op_code, cfg_num_acc, cfg_num_out,
             cfg_acc_from_buf, cfg_rd_base, cfg_wr_base, in_valid,
      input  cfg_ready, ctrl, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/pe_ctrl_gen.sv
// ============================================================================
// Module      : pe_ctrl_gen
// Description : Sequences one layer-tile command into per-cycle PE ctrl words
//               (accumulate / flush / write-back per output). The partial-sum
//               buffer-read path exists only with PE_CTRL_ACC_FROM_BUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_ctrl_gen #(
   parameter int PE_BUF_ADDR_WIDTH = 10,
   parameter int OP_CODE_WIDTH     = 3,
   parameter int CNT_WIDTH         = 16
) (
   input  wire           clk,
   input  wire           reset,
   pe_ctrl_gen_if.master bus
);
   localparam int AW = PE_BUF_ADDR_WIDTH;
   localparam int OW = OP_CODE_WIDTH;
   localparam int CW = CNT_WIDTH;
   localparam int CTRL_WIDTH = 5 + OW + 2*AW;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACC   = 3'd1,
      S_FLUSH = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_state;
   logic [CTRL_WIDTH-1:0] r_ctrl;
   logic                  r_cfg_ready;
   logic                  r_busy;
   logic                  r_done;
   logic [OW-1:0]         r_op;
   logic [CW-1:0]         r_num_acc;
   logic [CW-1:0]         r_num_out;
   logic [CW-1:0]         r_acc_cnt;
   logic [CW-1:0]         r_out_cnt;
   logic [AW-1:0]         r_wr_addr;

   logic                  w_accept;
   logic                  w_acc_emit;
   logic [CW-1:0]         w_acc_base;
   logic [CW-1:0]         w_acc_cnt_nxt;
   logic [CW-1:0]         w_num_acc_tgt;
   logic [OW-1:0]         w_op_cur;
   logic                  w_step_rd_req;
   logic [AW-1:0]         w_step_rd_addr;
   logic [CTRL_WIDTH-1:0] w_acc_word;

   assign w_accept      = r_cfg_ready & bus.cfg_valid;
   assign w_num_acc_tgt = (bus.cfg_num_acc == '0) ? {{(CW-1){1'b0}}, 1'b1} : bus.cfg_num_acc;
   assign w_op_cur      = (r_state == S_IDLE) ? bus.cfg_op_code : r_op;
   // Accumulate count restarts at every output; only ACC carries it forward
   assign w_acc_base    = (r_state == S_ACC) ? r_acc_cnt : '0;
   assign w_acc_cnt_nxt = w_acc_base + {{(CW-1){1'b0}}, bus.in_valid};

   // Next edge emits an ACC word (as opposed to FLUSH / DONE / idle)
   always_comb begin
      w_acc_emit = 1'b0;
      case (r_state)
         S_IDLE:  w_acc_emit = w_accept && (bus.cfg_num_out != '0);
         S_ACC:   w_acc_emit = (r_acc_cnt != r_num_acc);
         S_WRITE: w_acc_emit = (r_out_cnt != (r_num_out - {{(CW-1){1'b0}}, 1'b1}));
         default: w_acc_emit = 1'b0;
      endcase
   end

`ifdef PE_CTRL_ACC_FROM_BUF_EN
   logic          r_acc_from_buf;
   logic [AW-1:0] r_rd_addr;
   logic          w_from_buf_cur;
   logic [AW-1:0] w_rd_cur;

   assign w_from_buf_cur = (r_state == S_IDLE) ? bus.cfg_acc_from_buf : r_acc_from_buf;
   assign w_rd_cur       = (r_state == S_IDLE) ? bus.cfg_rd_base : r_rd_addr;
   // Partial sum is fetched on the first enabled cycle of each output
   assign w_step_rd_req  = w_from_buf_cur & bus.in_valid & (w_acc_base == '0);
   assign w_step_rd_addr = w_step_rd_req ? w_rd_cur : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc_from_buf <= 1'b0;
         r_rd_addr      <= '0;
      end else begin
         if (w_accept) begin
            r_acc_from_buf <= bus.cfg_acc_from_buf;
         end
         if (w_acc_emit) begin
            r_rd_addr <= w_rd_cur + {{(AW-1){1'b0}}, w_step_rd_req};
         end
      end
   end
`else
   logic w_unused_rd;

   assign w_step_rd_req  = 1'b0;
   assign w_step_rd_addr = '0;
   assign w_unused_rd    = &{1'b0, bus.cfg_acc_from_buf, bus.cfg_rd_base};
`endif

   assign w_acc_word = {w_step_rd_addr, {AW{1'b0}}, 3'b000, w_step_rd_req, bus.in_valid, w_op_cur};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_ctrl      <= '0;
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_op        <= '0;
         r_num_acc   <= '0;
         r_num_out   <= '0;
         r_acc_cnt   <= '0;
         r_out_cnt   <= '0;
         r_wr_addr   <= '0;
      end else begin
         r_ctrl      <= '0;
         r_done      <= 1'b0;
         r_busy      <= 1'b1;
         r_cfg_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op      <= bus.cfg_op_code;
                  r_num_acc <= w_num_acc_tgt;
                  r_num_out <= bus.cfg_num_out;
                  r_wr_addr <= bus.cfg_wr_base;
                  r_out_cnt <= '0;
                  if (w_acc_emit) begin
                     r_ctrl    <= w_acc_word;
                     r_acc_cnt <= w_acc_cnt_nxt;
                     r_state   <= S_ACC;
                  end else begin
                     r_acc_cnt <= '0;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end else begin
                  r_busy      <= 1'b0;
                  r_cfg_ready <= 1'b1;
               end
            end
            S_ACC: begin
               if (w_acc_emit) begin
                  r_ctrl    <= w_acc_word;
                  r_acc_cnt <= w_acc_cnt_nxt;
               end else begin
                  r_ctrl    <= {{(2*AW){1'b0}}, 5'b10000, r_op};
                  r_acc_cnt <= '0;
                  r_state   <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               r_ctrl  <= {{AW{1'b0}}, r_wr_addr, 5'b01100, r_op};
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_wr_addr <= r_wr_addr + {{(AW-1){1'b0}}, 1'b1};
               r_out_cnt <= r_out_cnt + {{(CW-1){1'b0}}, 1'b1};
               if (w_acc_emit) begin
                  r_ctrl    <= w_acc_word;
                  r_acc_cnt <= w_acc_cnt_nxt;
                  r_state   <= S_ACC;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy      <= 1'b0;
               r_cfg_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ctrl      = r_ctrl;
   assign bus.cfg_ready = r_cfg_ready;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pe_ctrl_gen.sv
// ============================================================================
// Module      : tb_pe_ctrl_gen
// Description : Self-checking bench for pe_ctrl_gen: directed scenarios plus
//               randomized commands against a word-sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_ctrl_gen;
   localparam int W  = 10;
   localparam int O  = 3;
   localparam int C  = 16;
   localparam int CW = 8 + 2*W;
`ifdef PE_CTRL_ACC_FROM_BUF_EN
   localparam bit RD_EN = 1'b1;
`else
   localparam bit RD_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] rd;
      logic [W-1:0] wr;
      logic         flush;
      logic         wv;
      logic         wreq;
      logic         rreq;
      logic         en;
      logic [O-1:0] op;
   } word_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pe_ctrl_gen_if #(.PE_BUF_ADDR_WIDTH(W), .OP_CODE_WIDTH(O), .CNT_WIDTH(C)) bus ();

   pe_ctrl_gen #(.PE_BUF_ADDR_WIDTH(W), .OP_CODE_WIDTH(O), .CNT_WIDTH(C)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          iv [0:1023];
   word_t       exp_w [0:2047];
   logic        exp_d [0:2047];
   int          n_exp;
   logic [CW-1:0] cap_ctrl [0:2047];
   logic        cap_done [0:2047];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic bit ivget(input int i);
      return (i < 1024) ? iv[i] : 1'b1;
   endfunction

   task automatic fill_iv(input bit rnd);
      for (int i = 0; i < 1024; i++)
         iv[i] = (rnd && i < 900) ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   // Expected word per cycle: each output = ACC words until tgt enabled, then flush, write.
   task automatic build_model(input logic [2:0] op, input logic [15:0] nacc, input logic [15:0] nout,
                              input logic fb, input logic [9:0] rdb, input logic [9:0] wrb);
      int     c;
      int     tgt;
      int     k;
      bit     v;
      word_t  w;
      logic [9:0] rd;
      c     = 0;
      tgt   = (nacc == 0) ? 1 : int'(nacc);
      rd    = rdb;
      n_exp = 0;
      for (int o = 0; o < int'(nout); o++) begin
         k = 0;
         while (k < tgt) begin
            v = ivget(c);
            c++;
            w    = '0;
            w.op = op;
            w.en = v;
            if (v && k == 0 && fb && RD_EN) begin
               w.rreq = 1'b1;
               w.rd   = rd;
               rd     = rd + 10'd1;
            end
            if (v) k++;
            exp_w[n_exp] = w; exp_d[n_exp] = 1'b0; n_exp++;
         end
         w = '0; w.op = op; w.flush = 1'b1;
         exp_w[n_exp] = w; exp_d[n_exp] = 1'b0; n_exp++; c++;
         w = '0; w.op = op; w.wv = 1'b1; w.wreq = 1'b1; w.wr = wrb + 10'(o);
         exp_w[n_exp] = w; exp_d[n_exp] = 1'b0; n_exp++; c++;
      end
      exp_w[n_exp] = '0; exp_d[n_exp] = 1'b1; n_exp++;
   endtask

   task automatic scramble_cfg();
      bus.cfg_op_code      = 3'($urandom);
      bus.cfg_num_acc      = 16'($urandom_range(0, 7));
      bus.cfg_num_out      = 16'($urandom_range(0, 7));
      bus.cfg_acc_from_buf = 1'($urandom);
      bus.cfg_rd_base      = 10'($urandom);
      bus.cfg_wr_base      = 10'($urandom);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " ctrl"}, bus.ctrl, 0);
      chk({tag, " busy"}, bus.busy, 0);
      chk({tag, " done"}, bus.done, 0);
      chk({tag, " cfg_ready"}, bus.cfg_ready, 1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cfg_valid = 1'b0;
         bus.in_valid  = 1'($urandom);
         scramble_cfg();
         @(negedge clk);
         chk_idle("idle");
      end
   endtask

   // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle.
   task automatic run_cmd(input logic [2:0] op, input logic [15:0] nacc, input logic [15:0] nout,
                          input logic fb, input logic [9:0] rdb, input logic [9:0] wrb);
      build_model(op, nacc, nout, fb, rdb, wrb);
      bus.cfg_valid        = 1'b1;
      bus.cfg_op_code      = op;
      bus.cfg_num_acc      = nacc;
      bus.cfg_num_out      = nout;
      bus.cfg_acc_from_buf = fb;
      bus.cfg_rd_base      = rdb;
      bus.cfg_wr_base      = wrb;
      bus.in_valid         = ivget(0);
      @(posedge clk);
      for (int j = 0; j < n_exp; j++) begin
         @(negedge clk);
         bus.cfg_valid = 1'($urandom_range(0, 1));
         scramble_cfg();
         bus.in_valid  = ivget(j + 1);
         cap_ctrl[j] = bus.ctrl;
         cap_done[j] = bus.done;
         chk($sformatf("ctrl[%0d]", j), bus.ctrl, exp_w[j]);
         chk($sformatf("busy[%0d]", j), bus.busy, 1);
         chk($sformatf("done[%0d]", j), bus.done, exp_d[j]);
         chk($sformatf("cfg_ready[%0d]", j), bus.cfg_ready, 0);
      end
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      chk_idle("post");
   endtask

   initial begin
      reset = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b0;
      scramble_cfg();
      #1;
      chk("rst ctrl", bus.ctrl, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst cfg_ready", bus.cfg_ready, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rel cfg_ready", bus.cfg_ready, 1);

      // Basic command
      fill_iv(1'b0);
      run_cmd(3'd3, 16'd4, 16'd2, 1'b0, 10'h000, 10'h010);
      chk("basic w0",  cap_ctrl[0],  28'h000000B);
      chk("basic w4",  cap_ctrl[4],  28'h0000083);
      chk("basic w5",  cap_ctrl[5],  28'h0001063);
      chk("basic w11", cap_ctrl[11], 28'h0001163);
      chk("basic done@12", cap_done[12], 1);

      // Stall of 3 cycles mid-ACC
      fill_iv(1'b0);
      iv[2] = 1'b0; iv[3] = 1'b0; iv[4] = 1'b0;
      run_cmd(3'd3, 16'd4, 16'd2, 1'b0, 10'h000, 10'h010);
      chk("stall w3", cap_ctrl[3], 28'h0000003);
      chk("stall done@15", cap_done[15], 1);

      // Wrap and buffer read
      fill_iv(1'b0);
      run_cmd(3'd2, 16'd2, 16'd2, 1'b1, 10'h3FF, 10'h3FF);
      chk("wrap w0", cap_ctrl[0], RD_EN ? 28'hFFC001A : 28'h000000A);
      chk("wrap w3", cap_ctrl[3], 28'h003FF62);
      chk("wrap w4", cap_ctrl[4], RD_EN ? 28'h000001A : 28'h000000A);
      chk("wrap w7", cap_ctrl[7], 28'h0000062);

      // num_out = 0
      idle_cycles(1);
      run_cmd(3'd6, 16'd3, 16'd0, 1'b1, 10'h100, 10'h200);
      chk("empty w0", cap_ctrl[0], 0);
      chk("empty done@0", cap_done[0], 1);

      // num_acc = 0 behaves as 1
      run_cmd(3'd5, 16'd0, 16'd2, 1'b0, 10'h000, 10'h020);
      chk("nacc0 w0", cap_ctrl[0], 28'h000000D);
      chk("nacc0 w2", cap_ctrl[2], 28'h0002065);
      chk("nacc0 done@6", cap_done[6], 1);

      // Reset mid-ACC
      fill_iv(1'b0);
      bus.cfg_valid = 1'b1; bus.cfg_op_code = 3'd4; bus.cfg_num_acc = 16'd8;
      bus.cfg_num_out = 16'd2; bus.cfg_acc_from_buf = 1'b0; bus.cfg_wr_base = 10'h0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      chk("pre-rst busy", bus.busy, 1);
      reset = 1'b0;
      #1;
      chk("async rst ctrl", bus.ctrl, 0);
      chk("async rst busy", bus.busy, 0);
      chk("async rst cfg_ready", bus.cfg_ready, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("in rst ctrl", bus.ctrl, 0);
         chk("in rst busy", bus.busy, 0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk_idle("after rst");
      run_cmd(3'd1, 16'd1, 16'd1, 1'b0, 10'h000, 10'h000);

      // Randomized commands
      for (int t = 0; t < 30; t++) begin
         fill_iv(1'b1);
         idle_cycles($urandom_range(0, 2));
         run_cmd(3'($urandom), 16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
                 1'($urandom),
                 ($urandom_range(0, 1) != 0) ? 10'h3FE : 10'($urandom),
                 ($urandom_range(0, 1) != 0) ? 10'h3FE : 10'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
